// File: rtl/rand_seq_checker.sv
// Receive-side checker for the 6-bit LFSR data path (feedback s[5]^s[3]^s[1]).
// Collects a seed from the bitstream, then flywheels a local copy and flags mismatches.
module rand_seq_checker #(
    parameter int ERR_LIMIT = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 resync,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 zero_seed,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [5:0]           data_out,
    output logic [1:0]           state_out,
    output logic [2:0]           shift_count_out
);

    typedef enum logic [1:0] {
        SEED   = 2'b00,
        LOCKED = 2'b01
    } state_t;

    localparam logic [2:0] LIMIT = 3'(ERR_LIMIT);

    state_t               state_q, state_d;
    logic [5:0]           data_q, data_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [2:0]           miss_q, miss_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 zero_seed_q, zero_seed_d;

    logic [5:0] seed_next;
    logic       pred;
    logic [2:0] miss_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEED;
            data_q      <= '0;
            cnt_q       <= '0;
            miss_q      <= '0;
            err_q       <= '0;
            err_pulse_q <= 1'b0;
            zero_seed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            miss_q      <= miss_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
            zero_seed_q <= zero_seed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        miss_d      = miss_q;
        err_d       = err_q;
        err_pulse_d = 1'b0;
        zero_seed_d = 1'b0;
        seed_next   = {data_q[4:0], bit_in};
        pred        = data_q[5] ^ data_q[3] ^ data_q[1];
        miss_inc    = miss_q + 3'd1;

        if (resync) begin
            state_d = SEED;
            data_d  = '0;
            cnt_d   = '0;
            miss_d  = '0;
            err_d   = '0;
        end else begin
            case (state_q)
                SEED: begin
                    if (bit_valid) begin
                        if (cnt_q == 3'd5) begin
                            cnt_d = '0;
                            // An all-zero seed would lock the flywheel at zero forever.
                            if (seed_next != 6'd0) begin
                                state_d = LOCKED;
                                data_d  = seed_next;
                                miss_d  = '0;
                            end else begin
                                data_d      = '0;
                                zero_seed_d = 1'b1;
                            end
                        end else begin
                            data_d = seed_next;
                            cnt_d  = cnt_q + 3'd1;
                        end
                    end
                end
                LOCKED: begin
                    cnt_d = '0;
                    if (bit_valid) begin
                        // Flywheel: the received bit is compared, never loaded.
                        data_d = {data_q[4:0], pred};
                        if (bit_in != pred) begin
                            err_pulse_d = 1'b1;
                            if (err_q != '1) begin
                                err_d = err_q + ERR_CNT_W'(1);
                            end
                            if (miss_inc == LIMIT) begin
                                state_d = SEED;
                                data_d  = '0;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_inc;
                            end
                        end else begin
                            miss_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = SEED;
                    data_d  = '0;
                    cnt_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    assign locked          = (state_q == LOCKED);
    assign err_pulse       = err_pulse_q;
    assign zero_seed       = zero_seed_q;
    assign err_count       = err_q;
    assign data_out        = data_q;
    assign state_out       = state_q;
    assign shift_count_out = cnt_q;

endmodule

// File: tb/tb_rand_seq_checker.sv
// Bench for rand_seq_checker: reference model feeds a scoreboard queue, plus directed checks.
// A second instance with a 2-bit error counter exercises counter saturation.
module tb_rand_seq_checker;

    logic clk = 1'b0;
    logic rst, resync, bit_valid, bit_in;

    logic       lk_a, ep_a, zs_a;
    logic [7:0] ec_a;
    logic [5:0] d_a;
    logic [1:0] st_a;
    logic [2:0] sc_a;

    logic       lk_b, ep_b, zs_b;
    logic [1:0] ec_b;
    logic [5:0] d_b;
    logic [1:0] st_b;
    logic [2:0] sc_b;

    rand_seq_checker #(.ERR_LIMIT(3), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .resync(resync), .bit_valid(bit_valid), .bit_in(bit_in),
        .locked(lk_a), .err_pulse(ep_a), .zero_seed(zs_a), .err_count(ec_a),
        .data_out(d_a), .state_out(st_a), .shift_count_out(sc_a)
    );

    rand_seq_checker #(.ERR_LIMIT(3), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .resync(resync), .bit_valid(bit_valid), .bit_in(bit_in),
        .locked(lk_b), .err_pulse(ep_b), .zero_seed(zs_b), .err_count(ec_b),
        .data_out(d_b), .state_out(st_b), .shift_count_out(sc_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lk;
        logic [5:0] d;
        logic [1:0] st;
        int         sc;
        logic       ep;
        logic       zs;
        int         ec;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    int         m_st, m_cnt, m_miss, m_err;
    logic [5:0] m_d;
    logic       m_ep, m_zs;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic fb(input logic [5:0] d);
        return ^(d & 6'b101010);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_miss = 0; m_err = 0; m_d = 6'd0; m_ep = 0; m_zs = 0;
    endtask

    task automatic model_step(input logic r, input logic v, input logic b);
        logic e;
        m_ep = 0; m_zs = 0;
        if (r) begin
            model_reset();
        end else if (v && m_st == 0) begin
            m_d = {m_d[4:0], b};
            if (m_cnt == 5) begin
                m_cnt = 0;
                if (m_d == 6'd0) m_zs = 1;
                else begin m_st = 1; m_miss = 0; end
            end else m_cnt++;
        end else if (v && m_st == 1) begin
            e   = fb(m_d);
            m_d = {m_d[4:0], e};
            if (b != e) begin
                m_ep = 1; m_err++; m_miss++;
                if (m_miss == 3) begin m_st = 0; m_cnt = 0; m_d = 6'd0; m_miss = 0; end
            end else m_miss = 0;
        end
    endtask

    task automatic step(input logic v, input logic b, input logic r = 1'b0);
        exp_t x, y;
        bit_valid = v; bit_in = b; resync = r;
        model_step(r, v, b);
        x.lk = (m_st == 1); x.d = m_d; x.st = 2'(m_st); x.sc = m_cnt;
        x.ep = m_ep; x.zs = m_zs; x.ec = m_err;
        sb.push_back(x);
        @(posedge clk); #1;
        y = sb.pop_front();
        check("sb_locked", int'(lk_a), int'(y.lk));
        check("sb_data",   int'(d_a),  int'(y.d));
        check("sb_state",  int'(st_a), int'(y.st));
        check("sb_shift",  int'(sc_a), y.sc);
        check("sb_errp",   int'(ep_a), int'(y.ep));
        check("sb_zseed",  int'(zs_a), int'(y.zs));
        check("sb_errcnt", int'(ec_a), sat(y.ec, 255));
        check("sb_errcnt_w2", int'(ec_b), sat(y.ec, 3));
        check("sb_locked_w2", int'(lk_b), int'(y.lk));
        bit_valid = 1'b0; resync = 1'b0;
    endtask

    task automatic seed(input logic [5:0] s);
        for (int i = 5; i >= 0; i--) step(1'b1, s[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, int'(lk_a), 0);
        check({tag, "_data"},   int'(d_a), 0);
        check({tag, "_state"},  int'(st_a), 0);
        check({tag, "_shift"},  int'(sc_a), 0);
        check({tag, "_errp"},   int'(ep_a), 0);
        check({tag, "_zseed"},  int'(zs_a), 0);
        check({tag, "_errcnt"}, int'(ec_a), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; resync = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Test 1: seed 101101, then flywheel 0,0,1
        seed(6'b101101);
        check("t1_locked", int'(lk_a), 1);
        check("t1_seed",   int'(d_a), 6'b101101);
        step(1'b1, 1'b0); check("t1_d1", int'(d_a), 6'b011010);
        step(1'b1, 1'b0); check("t1_d2", int'(d_a), 6'b110100);
        step(1'b1, 1'b1); check("t1_d3", int'(d_a), 6'b101001);
        check("t1_errcnt", int'(ec_a), 0);

        // Test 2: one bad bit keeps lock and prediction
        step(1'b0, 1'b0, 1'b1);
        seed(6'b101101);
        step(1'b1, 1'b1);
        check("t2_errp",   int'(ep_a), 1);
        check("t2_errcnt", int'(ec_a), 1);
        check("t2_locked", int'(lk_a), 1);
        check("t2_data",   int'(d_a), 6'b011010);
        step(1'b0, 1'b0);
        check("t2_errp_clr", int'(ep_a), 0);

        // Test 3: three consecutive wrong bits drop lock, then relock
        step(1'b0, 1'b0, 1'b1);
        seed(6'b101101);
        for (int i = 0; i < 3; i++) step(1'b1, ~fb(m_d));
        check("t3_locked", int'(lk_a), 0);
        check("t3_state",  int'(st_a), 0);
        check("t3_shift",  int'(sc_a), 0);
        check("t3_errcnt", int'(ec_a), 3);
        seed(6'b101101);
        check("t3_relock", int'(lk_a), 1);
        check("t3_errcnt_kept", int'(ec_a), 3);

        // Test 4: zero seed rejected, valid gaps hold the count
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        check("t4_gap_shift", int'(sc_a), 3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("t4_zseed", int'(zs_a), 1);
        check("t4_state", int'(st_a), 0);
        check("t4_shift", int'(sc_a), 0);
        step(1'b0, 1'b0);
        check("t4_zseed_clr", int'(zs_a), 0);

        // Test 5: resync overrides a valid bit; async rst mid-seed
        seed(6'b110011);
        step(1'b1, ~fb(m_d));
        step(1'b1, 1'b1, 1'b1);
        check("t5_state",  int'(st_a), 0);
        check("t5_errcnt", int'(ec_a), 0);
        check("t5_data",   int'(d_a), 0);
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        check("t5_pre_rst_shift", int'(sc_a), 3);
        rst = 1'b1;
        #1;
        check_all_zero("t5_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Test 6: five isolated errors saturate the 2-bit counter, lock retained
        seed(6'b101101);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ~fb(m_d));
            step(1'b1, fb(m_d));
            step(1'b1, fb(m_d));
        end
        check("t6_errcnt_w2", int'(ec_b), 3);
        check("t6_errcnt_w8", int'(ec_a), 5);
        check("t6_locked_w2", int'(lk_b), 1);
        check("t6_locked_w8", int'(lk_a), 1);
        check("t6_data_w2",   int'(d_b), int'(d_a));

        // Random stimulus against the model
        for (int i = 0; i < 200; i++) begin
            logic v, b, r;
            v = ($urandom_range(0, 3) != 0);
            b = (m_st == 1 && $urandom_range(0, 5) != 0) ? fb(m_d) : 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 60) == 0);
            step(v, b, r);
        end

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
